// File: rtl/pipeline_regfile.sv
// 32 x XLEN integer register file with a per-register pending-write scoreboard for ID-stage stalls.
// Optional same-cycle write-through and stall release: define REGFILE_BYPASS_EN.
module pipeline_regfile #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int IDX_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                regWriteEnW_i,
  input  logic [IDX_W-1:0]    rdW_i,
  input  logic [XLEN-1:0]     writeBackDataW_i,
  input  logic [IDX_W-1:0]    rs1D_i,
  input  logic [IDX_W-1:0]    rs2D_i,
  input  logic                useRs1D_i,
  input  logic                useRs2D_i,
  input  logic                issueEnD_i,
  input  logic [IDX_W-1:0]    issueRdD_i,
  input  logic                flushAll_i,
  output logic [XLEN-1:0]     rs1DataD_o,
  output logic [XLEN-1:0]     rs2DataD_o,
  output logic                stallD_o,
  output logic [NUM_REGS-1:0] busyVec_o
);

  // An index is live when it names a real, writable register (not x0, not out of range).
  function automatic logic isLive(input logic [IDX_W-1:0] idx);
    return (idx != '0) && (int'(idx) < NUM_REGS);
  endfunction

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busyNext;
  logic                w_wbLive;
  logic                w_hazard1;
  logic                w_hazard2;

  assign w_wbLive = regWriteEnW_i && isLive(rdW_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wbLive) begin
      r_regs[rdW_i] <= writeBackDataW_i;
    end
  end

  // Flush beats everything; a new producer's set beats the old producer's clear.
  always_comb begin
    w_busyNext = r_busy;
    if (flushAll_i) begin
      w_busyNext = '0;
    end else begin
      if (w_wbLive) begin
        w_busyNext[rdW_i] = 1'b0;
      end
      if (issueEnD_i && isLive(issueRdD_i)) begin
        w_busyNext[issueRdD_i] = 1'b1;
      end
    end
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_wbHit1;
  logic w_wbHit2;

  assign w_wbHit1 = w_wbLive && (rdW_i == rs1D_i);
  assign w_wbHit2 = w_wbLive && (rdW_i == rs2D_i);

  always_comb begin
    rs1DataD_o = '0;
    rs2DataD_o = '0;
    if (!reset && isLive(rs1D_i)) begin
      rs1DataD_o = w_wbHit1 ? writeBackDataW_i : r_regs[rs1D_i];
    end
    if (!reset && isLive(rs2D_i)) begin
      rs2DataD_o = w_wbHit2 ? writeBackDataW_i : r_regs[rs2D_i];
    end
  end

  // The retiring producer's value is forwarded, so its consumer need not wait.
  assign w_hazard1 = useRs1D_i && isLive(rs1D_i) && r_busy[rs1D_i] && !w_wbHit1;
  assign w_hazard2 = useRs2D_i && isLive(rs2D_i) && r_busy[rs2D_i] && !w_wbHit2;
`else
  always_comb begin
    rs1DataD_o = '0;
    rs2DataD_o = '0;
    if (!reset && isLive(rs1D_i)) begin
      rs1DataD_o = r_regs[rs1D_i];
    end
    if (!reset && isLive(rs2D_i)) begin
      rs2DataD_o = r_regs[rs2D_i];
    end
  end

  assign w_hazard1 = useRs1D_i && isLive(rs1D_i) && r_busy[rs1D_i];
  assign w_hazard2 = useRs2D_i && isLive(rs2D_i) && r_busy[rs2D_i];
`endif

  assign stallD_o  = !reset && (w_hazard1 || w_hazard2);
  assign busyVec_o = r_busy;

endmodule

// File: tb/tb_pipeline_regfile.sv
// Directed self-checking bench for pipeline_regfile; expectations follow REGFILE_BYPASS_EN when defined.
module tb_pipeline_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        regWriteEnW;
  logic [4:0]  rdW;
  logic [31:0] writeBackDataW;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic        useRs1D;
  logic        useRs2D;
  logic        issueEnD;
  logic [4:0]  issueRdD;
  logic        flushAll;
  logic [31:0] rs1DataD;
  logic [31:0] rs2DataD;
  logic        stallD;
  logic [31:0] busyVec;

  int vectorCount = 0;
  int missCount   = 0;

  pipeline_regfile dut (
    .clk              (clk),
    .reset            (reset),
    .regWriteEnW_i    (regWriteEnW),
    .rdW_i            (rdW),
    .writeBackDataW_i (writeBackDataW),
    .rs1D_i           (rs1D),
    .rs2D_i           (rs2D),
    .useRs1D_i        (useRs1D),
    .useRs2D_i        (useRs2D),
    .issueEnD_i       (issueEnD),
    .issueRdD_i       (issueRdD),
    .flushAll_i       (flushAll),
    .rs1DataD_o       (rs1DataD),
    .rs2DataD_o       (rs2DataD),
    .stallD_o         (stallD),
    .busyVec_o        (busyVec)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives every DUT input, then lets the combinational outputs settle.
  task automatic applyStimulus(
    input logic we, input logic [4:0] rd, input logic [31:0] data,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic use1, input logic use2,
    input logic issEn, input logic [4:0] issRd, input logic flush);
    regWriteEnW    = we;
    rdW            = rd;
    writeBackDataW = data;
    rs1D           = rs1;
    rs2D           = rs2;
    useRs1D        = use1;
    useRs2D        = use2;
    issueEnD       = issEn;
    issueRdD       = issRd;
    flushAll       = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    #2;
    checkOutput("reset_rs1",   rs1DataD, 32'h0);
    checkOutput("reset_busy",  busyVec,  32'h0);
    checkOutput("reset_stall", {31'h0, stallD}, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("post_reset_x5",  rs1DataD, 32'h0);
    checkOutput("post_reset_x31", rs2DataD, 32'h0);

    // Write x5 and x0.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("x5_same_cycle", rs1DataD, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("x5_next_cycle", rs1DataD, 32'hDEADBEEF);
    checkOutput("x0_same_cycle", rs2DataD, 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("x0_after_write", rs2DataD, 32'h0);

    // x7 old value then same-cycle overwrite.
    applyStimulus(1'b1, 5'd7, 32'h11111111, 5'd7, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("x7_same_cycle", rs1DataD, BYP ? 32'hA5A5A5A5 : 32'h11111111);
    checkOutput("x5_other_port", rs2DataD, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("x7_next_cycle", rs1DataD, 32'hA5A5A5A5);

    // RAW hazard on x3.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("raw_busy3",  busyVec, 32'h0000_0008);
    checkOutput("raw_stall1", {31'h0, stallD}, 32'h1);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("raw_unused_rs1", {31'h0, stallD}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("raw_stall_rs2", {31'h0, stallD}, 32'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("raw_stall_hold", {31'h0, stallD}, 32'h1);
    tick();
    applyStimulus(1'b1, 5'd3, 32'h00000033, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("raw_wb_stall", {31'h0, stallD}, BYP ? 32'h0 : 32'h1);
    checkOutput("raw_wb_busy",  busyVec, 32'h0000_0008);
    checkOutput("raw_wb_data",  rs1DataD, BYP ? 32'h00000033 : 32'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("raw_after_stall", {31'h0, stallD}, 32'h0);
    checkOutput("raw_after_busy",  busyVec, 32'h0);
    checkOutput("raw_after_data",  rs1DataD, 32'h00000033);

    // Simultaneous set and clear of x9.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    tick();
    checkOutput("sc_busy9_set", busyVec, 32'h0000_0200);
    applyStimulus(1'b1, 5'd9, 32'h99, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
    tick();
    checkOutput("sc_set_wins", busyVec, 32'h0000_0200);
    applyStimulus(1'b1, 5'd9, 32'h9A, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("sc_cleared", busyVec, 32'h0);

    // Flush beats issue; issue of x0 never marks busy.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0);
    tick();
    checkOutput("flush_pre_busy2", busyVec, 32'h0000_0004);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
    tick();
    checkOutput("flush_beats_issue", busyVec, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    tick();
    checkOutput("issue_x0_ignored", busyVec, 32'h0);

    // Asynchronous reset mid-operation with a write pending.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd8, 32'hCAFEF00D, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("pre_areset_stall", {31'h0, stallD}, 32'h1);
    checkOutput("pre_areset_busy",  busyVec, 32'h0000_0040);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_x5",    rs1DataD, 32'h0);
    checkOutput("areset_busy",  busyVec,  32'h0);
    checkOutput("areset_stall", {31'h0, stallD}, 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd8, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("areset_x8_discarded", rs1DataD, 32'h0);
    checkOutput("areset_x7_cleared",   rs2DataD, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/pipeline_regfile.md
Name: pipeline_regfile

Overview:
- 32 x 32-bit integer register file at the receiving end of the write-back interface.
- Accepts the registered write-back triple (enable, rd, data) from the WB stage.
- Serves two read ports to the ID stage.
- Holds a per-register pending-write scoreboard, so ID can stall on operands whose producer has not yet written back.
- Lives in the ID stage of the 5-stage pipeline.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 always included.
- XLEN, 32, register data width.
- IDX_W, 5, register index width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- regWriteEnW_i  input  1  write-back enable from WB.
- rdW_i  input  IDX_W  write-back destination index.
- writeBackDataW_i  input  XLEN  write-back data.
- rs1D_i  input  IDX_W  read port 1 index.
- rs2D_i  input  IDX_W  read port 2 index.
- useRs1D_i  input  1  ID instruction actually consumes rs1.
- useRs2D_i  input  1  ID instruction actually consumes rs2.
- issueEnD_i  input  1  ID instruction leaves ID this cycle and will write rd.
- issueRdD_i  input  IDX_W  rd of the issuing instruction.
- flushAll_i  input  1  pipeline flush; clears all pending marks.
- rs1DataD_o  output  XLEN  read data port 1 (combinational).
- rs2DataD_o  output  XLEN  read data port 2 (combinational).
- stallD_o  output  1  operand hazard: hold the ID instruction.
- busyVec_o  output  NUM_REGS  current scoreboard bits; bit 0 is always 0.

Behaviour:
- Reset (asynchronous, active-high): all registers = 0, all busy bits = 0.
  - stallD_o = 0 and outputs read 0 while reset is held.
  - A reset asserted mid-operation discards the pending write and all busy marks immediately.
- Write:
  - On the rising edge with regWriteEnW_i = 1 and rdW_i != 0: reg[rdW_i] <= writeBackDataW_i.
  - Writes to x0 are ignored; x0 always reads 0.
- Read:
  - rsXDataD_o = 0 if rsX = 0, otherwise reg[rsX].
  - Zero latency (combinational from index).
  - Same-cycle write behaviour depends on the optional feature.
- Scoreboard, per register r != 0, next state:
  - flushAll_i = 1 -> busy[r] = 0. Flush beats issue and write-back in the same cycle.
  - issueEnD_i = 1 and issueRdD_i = r -> busy[r] = 1. Set beats clear, so a new producer wins over the old one retiring in the same cycle.
  - regWriteEnW_i = 1 and rdW_i = r -> busy[r] = 0.
  - Otherwise busy[r] holds.
  - issueRdD_i = 0 never sets a bit.
  - At most one in-flight producer per register is tracked; the pipeline guarantees in-order retire.
- Stall (combinational):
  - stallD_o = (useRs1D_i and rs1D_i != 0 and hazard(rs1D_i)) or (useRs2D_i and rs2D_i != 0 and hazard(rs2D_i)).
  - hazard(r) = busy[r], excluding the same-cycle write-back case governed by the optional feature.
  - The issuing block must not assert issueEnD_i while stallD_o = 1; the stall does not gate issue internally.
- Width rules:
  - Indices >= NUM_REGS (when NUM_REGS < 2^IDX_W) read 0, never stall, and are ignored on write and issue.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through. If regWriteEnW_i = 1, rdW_i = rsX and rsX != 0, then rsXDataD_o = writeBackDataW_i in the same cycle.
  - hazard(r) excludes r == rdW_i with regWriteEnW_i = 1, so no stall in the retiring cycle.
- Undefined:
  - Reads return the stored value only; the new value is visible the cycle after the write edge.
  - hazard(r) = busy[r]; stall holds through the write-back cycle and releases on the next cycle.

Test Plan:
- Reset then read:
  - Assert reset asynchronously mid-cycle -> all reads 0 and busyVec_o = 0 immediately.
  - Release reset, read x5/x31 -> 0.
- Basic write/read:
  - Write x5 = 0xDEADBEEF -> rs1D_i = 5 reads 0xDEADBEEF from the next cycle.
  - Write x0 = 0x12345678 -> rs2D_i = 0 still reads 0.
- Same-cycle write/read of x7 = 0xA5A5A5A5:
  - With REGFILE_BYPASS_EN -> rs1DataD_o = 0xA5A5A5A5 in that cycle.
  - Without it -> old value in that cycle, new value next cycle.
- RAW stall, issue rd = 3 with useRs1D_i = 1 and rs1D_i = 3:
  - stallD_o = 1 until write-back of x3.
  - Release in the write-back cycle (bypass) or one cycle later (no bypass).
  - busyVec_o[3] tracks the hazard throughout.
- Simultaneous set/clear: issue rd = 9 while WB writes x9 -> busy[9] stays 1.
- Flush vs issue: flushAll_i with issueEnD_i (rd = 4) and busy[2] = 1 -> busyVec_o = 0 next cycle.
